// File: rtl/ysyx_25030093_wb_sched.sv
// Write-back scheduler: EXU/LSU arbitration onto the RF write port, plus a RAW scoreboard.
// Define YSYX_25030093_WB_RR_EN for round-robin tie-break (default: LSU wins ties).
module ysyx_25030093_wb_sched #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   output logic                  iss_ready,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic exu_win;

`ifdef YSYX_25030093_WB_RR_EN
   logic lsu_last_q, lsu_last_d;

   assign exu_win = lsu_last_q;

   always_comb begin
      lsu_last_d = lsu_last_q;
      if (exu_ready)
         lsu_last_d = 1'b0;
      else if (lsu_ready)
         lsu_last_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lsu_last_q <= 1'b1;
      else
         lsu_last_q <= lsu_last_d;
   end
`else
   assign exu_win = 1'b0;
`endif

   assign exu_ready = exu_valid & (~lsu_valid | exu_win);
   assign lsu_ready = lsu_valid & (~exu_valid | ~exu_win);

   logic                  wen_q, wen_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   // r0 writes still go through the stage so address/data are visible
   always_comb begin
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (exu_ready) begin
         wen_d   = |exu_rd;
         waddr_d = exu_rd;
         wdata_d = exu_data;
      end else if (lsu_ready) begin
         wen_d   = |lsu_rd;
         waddr_d = lsu_rd;
         wdata_d = lsu_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign rf_wen   = wen_q;
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;

   logic [1:0]      cnt_q [NREG];
   logic [1:0]      cnt_d [NREG];
   logic [NREG-1:0] inc_v;
   logic [NREG-1:0] dec_v;

   assign iss_ready = (cnt_q[iss_rd] != 2'd3) | (iss_rd == '0);
   assign rs1_busy  = (cnt_q[rs1_addr] != 2'd0) & (|rs1_addr);
   assign rs2_busy  = (cnt_q[rs2_addr] != 2'd0) & (|rs2_addr);

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         inc_v[r] = iss_valid & iss_ready
                  & (iss_rd == ADDR_WIDTH'(r));
         dec_v[r] = wen_q & (waddr_q == ADDR_WIDTH'(r));
         cnt_d[r] = cnt_q[r];
         case ({inc_v[r], dec_v[r]})
            2'b10:   cnt_d[r] = cnt_q[r] + 2'd1;
            2'b01:   if (cnt_q[r] != 2'd0)
                        cnt_d[r] = cnt_q[r] - 2'd1;
            default: cnt_d[r] = cnt_q[r];
         endcase
      end
      cnt_d[0] = 2'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++)
            cnt_q[r] <= 2'd0;
      end else begin
         for (int r = 0; r < NREG; r++)
            cnt_q[r] <= cnt_d[r];
      end
   end

endmodule

// File: tb/tb_ysyx_25030093_wb_sched.sv
// Randomized + directed bench for ysyx_25030093_wb_sched against a queue/array model.
module tb_ysyx_25030093_wb_sched;

   logic        clk, rst;
   logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
   logic [4:0]  exu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr, rf_waddr;
   logic [31:0] exu_data, lsu_data, rf_wdata;
   logic        iss_valid, iss_ready, rs1_busy, rs2_busy, rf_wen;

`ifdef YSYX_25030093_WB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   ysyx_25030093_wb_sched #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .exu_ready(exu_ready),
      .exu_rd(exu_rd), .exu_data(exu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } req_t;

   req_t        exu_q[$];
   req_t        lsu_q[$];
   logic [4:0]  log_q[$];
   int          cnt[32];
   bit          lsu_last, exu_hold, lsu_hold, rnd_mode;
   bit          m_wen;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int          n_assert = 0;
   int          n_fail = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      foreach (cnt[i]) cnt[i] = 0;
      lsu_last = 1'b1;
      m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
      exu_q.delete(); lsu_q.delete();
      exu_hold = 1'b0; lsu_hold = 1'b0;
   endtask

   function automatic bit busy_of(logic [4:0] a);
      return (a != 0) && (cnt[a] > 0);
   endfunction

   // One clock: drive producers, check combinational outputs, advance model, check RF port.
   task automatic cycle();
      bit eg, lg, ia, exp_ir, inc, dec;
      req_t g;
      exu_valid = (exu_q.size() > 0) &&
                  (exu_hold || !rnd_mode || $urandom_range(1, 0) == 1);
      lsu_valid = (lsu_q.size() > 0) &&
                  (lsu_hold || !rnd_mode || $urandom_range(1, 0) == 1);
      if (exu_valid) begin exu_rd = exu_q[0].rd; exu_data = exu_q[0].d; end
      if (lsu_valid) begin lsu_rd = lsu_q[0].rd; lsu_data = lsu_q[0].d; end
      #1;
      eg = exu_valid && (!lsu_valid || (RR && lsu_last));
      lg = lsu_valid && !eg;
      exp_ir = (iss_rd == 0) || (cnt[iss_rd] < 3);
      chk("exu_ready", 32'(exu_ready), 32'(eg));
      chk("lsu_ready", 32'(lsu_ready), 32'(lg));
      chk("iss_ready", 32'(iss_ready), 32'(exp_ir));
      chk("rs1_busy", 32'(rs1_busy), 32'(busy_of(rs1_addr)));
      chk("rs2_busy", 32'(rs2_busy), 32'(busy_of(rs2_addr)));
      ia = iss_valid && exp_ir;
      @(posedge clk);
      for (int r = 1; r < 32; r++) begin
         inc = ia && (iss_rd == r);
         dec = m_wen && (m_waddr == r);
         if (inc && !dec) cnt[r]++;
         else if (dec && !inc && cnt[r] > 0) cnt[r]--;
      end
      m_wen = 1'b0;
      if (eg || lg) begin
         g = eg ? exu_q.pop_front() : lsu_q.pop_front();
         lsu_last = lg;
         m_wen = (g.rd != 0);
         m_waddr = g.rd;
         m_wdata = g.d;
         log_q.push_back(g.rd);
      end
      exu_hold = exu_valid && !eg;
      lsu_hold = lsu_valid && !lg;
      #1;
      chk("rf_wen", 32'(rf_wen), 32'(m_wen));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("rf_wdata", rf_wdata, m_wdata);
   endtask

   initial begin
      logic [4:0] exp_log[4];
      rst = 1'b0; rnd_mode = 1'b0;
      exu_valid = 0; lsu_valid = 0; iss_valid = 0;
      exu_rd = 0; lsu_rd = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
      exu_data = 0; lsu_data = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wen", 32'(rf_wen), 0);
      chk("rst_waddr", 32'(rf_waddr), 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_exu_ready", 32'(exu_ready), 0);
      chk("rst_lsu_ready", 32'(lsu_ready), 0);
      chk("rst_busy", 32'({rs1_busy, rs2_busy}), 0);
      chk("rst_iss_ready", 32'(iss_ready), 1);
      rst = 1'b1;
      cycle();

      exu_q.push_back('{5'd5, 32'hDEADBEEF});
      cycle();
      chk("single_wen", 32'(rf_wen), 1);
      chk("single_waddr", 32'(rf_waddr), 5);
      chk("single_wdata", rf_wdata, 32'hDEADBEEF);
      cycle();
      chk("single_wen_off", 32'(rf_wen), 0);

      for (int i = 0; i < 4; i++) begin
         exu_q.push_back('{5'(i + 1), 32'(100 + i)});
         lsu_q.push_back('{5'(i + 11), 32'(200 + i)});
      end
      log_q.delete();
      repeat (4) cycle();
      if (RR) begin
         exp_log[0] = 1; exp_log[1] = 11; exp_log[2] = 2; exp_log[3] = 12;
      end else begin
         exp_log[0] = 11; exp_log[1] = 12; exp_log[2] = 13; exp_log[3] = 14;
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("tie_grant%0d", i), 32'(log_q[i]), 32'(exp_log[i]));
      repeat (5) cycle();

      iss_valid = 1; iss_rd = 7;
      cycle();
      iss_valid = 0; rs1_addr = 7;
      #1 chk("claim7_busy", 32'(rs1_busy), 1);
      exu_q.push_back('{5'd7, 32'h77});
      cycle();
      chk("w7_busy_n1", 32'(rs1_busy), 1);
      cycle();
      chk("w7_busy_n2", 32'(rs1_busy), 0);

      iss_valid = 1; iss_rd = 9;
      repeat (3) cycle();
      iss_valid = 0;
      #1 chk("sat9_ready", 32'(iss_ready), 0);
      exu_q.push_back('{5'd9, 32'h99});
      cycle();
      chk("w9_ready_n1", 32'(iss_ready), 0);
      cycle();
      chk("w9_ready_n2", 32'(iss_ready), 1);
      exu_q.push_back('{5'd9, 32'h999});
      cycle();
      iss_valid = 1;
      cycle();
      iss_valid = 0;
      #1 chk("same_cyc_ready", 32'(iss_ready), 1);
      iss_valid = 1;
      cycle();
      iss_valid = 0;
      #1 chk("same_cyc_sat", 32'(iss_ready), 0);

      iss_valid = 1; iss_rd = 0; rs1_addr = 0;
      exu_q.push_back('{5'd0, 32'h123});
      cycle();
      chk("r0_wen", 32'(rf_wen), 0);
      chk("r0_waddr", 32'(rf_waddr), 0);
      chk("r0_wdata", rf_wdata, 32'h123);
      cycle();
      chk("r0_busy", 32'(rs1_busy), 0);
      chk("r0_iss_ready", 32'(iss_ready), 1);
      iss_valid = 0;

      rnd_mode = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if (exu_q.size() < 2)
            exu_q.push_back('{5'($urandom_range(7, 0)), $urandom});
         if (lsu_q.size() < 2)
            lsu_q.push_back('{5'($urandom_range(7, 0)), $urandom});
         iss_valid = ($urandom_range(2, 0) == 0);
         iss_rd = 5'($urandom_range(7, 0));
         rs1_addr = 5'($urandom_range(7, 0));
         rs2_addr = 5'($urandom_range(7, 0));
         cycle();
      end
      rnd_mode = 1'b0;

      iss_valid = 1; iss_rd = 3; rs1_addr = 3;
      exu_q.delete(); lsu_q.delete();
      exu_hold = 0; lsu_hold = 0;
      exu_q.push_back('{5'd3, 32'h33});
      cycle();
      iss_valid = 0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_wen", 32'(rf_wen), 0);
      chk("mid_rst_waddr", 32'(rf_waddr), 0);
      chk("mid_rst_wdata", rf_wdata, 0);
      chk("mid_rst_busy", 32'(rs1_busy), 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
